// File: rtl/pipe_ir_buffer_if.sv
// pipe_ir_buffer_if: fetch-side inputs and pipeline-register outputs of the
// IF/EX and EX/WB instruction/PC buffers.
// master = pipeline control (drives fetch data, flush, enable)
// slave  = pipe_ir_buffer
interface pipe_ir_buffer_if;
  logic        en;
  logic [31:0] inst_in;
  logic [31:0] pc_in;
  logic        flush;
  logic [31:0] irbuffer1_out;
  logic [31:0] irbuffer2_out;
  logic [31:0] pc1_out;
  logic [31:0] pc2_out;
  logic        valid1_out;
  logic        valid2_out;
  logic        stall_out;

  modport master (
    output en, inst_in, pc_in, flush,
    input  irbuffer1_out, irbuffer2_out, pc1_out, pc2_out,
           valid1_out, valid2_out, stall_out
  );

  modport slave (
    input  en, inst_in, pc_in, flush,
    output irbuffer1_out, irbuffer2_out, pc1_out, pc2_out,
           valid1_out, valid2_out, stall_out
  );
endinterface

// File: rtl/pipe_ir_buffer.sv
// pipe_ir_buffer: IF/EX and EX/WB instruction/PC register chain of the
// 3-stage pipeline. Inserts bubbles (addi x0,x0,0) on flush and, when the
// macro LOAD_USE_STALL_EN is defined, on a load-use hazard (one cycle).
// Without LOAD_USE_STALL_EN the buffers always advance and stall_out is 0.
module pipe_ir_buffer (
  input  logic                   clk,
  input  logic                   rst,
  pipe_ir_buffer_if.slave        bus
);
  localparam logic [31:0] NOP     = 32'h0000_0013;
  localparam logic [6:0]  OP_LOAD = 7'b0000011;

  logic [31:0] r_ir1, r_ir2;
  logic [31:0] r_pc1, r_pc2;
  logic        r_valid1, r_valid2;

  logic        w_ld_use;
  logic        w_stall;

`ifdef LOAD_USE_STALL_EN
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_S    = 7'b0100011;
  localparam logic [6:0] OP_B    = 7'b1100011;
  localparam logic [6:0] OP_JALR = 7'b1100111;

  logic [6:0] w_op1, w_op_in;
  logic [4:0] w_rd1, w_rs1_in, w_rs2_in;
  logic       w_uses_rs1, w_uses_rs2;

  assign w_op1    = r_ir1[6:0];
  assign w_rd1    = r_ir1[11:7];
  assign w_op_in  = bus.inst_in[6:0];
  assign w_rs1_in = bus.inst_in[19:15];
  assign w_rs2_in = bus.inst_in[24:20];

  // Decode which source registers the fetched instruction actually reads.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    w_uses_rs1 = 1'b0;
    w_uses_rs2 = 1'b0;
    case (w_op_in)
      OP_R, OP_S, OP_B: begin
        w_uses_rs1 = 1'b1;
        w_uses_rs2 = 1'b1;
      end
      OP_I, OP_LOAD, OP_JALR: w_uses_rs1 = 1'b1;
      default: ;
    endcase
  end

  // A load in EX whose rd (non-x0) is read by the instruction being fetched.
  assign w_ld_use = r_valid1 && (w_op1 == OP_LOAD) && (w_rd1 != 5'd0) &&
                    ((w_uses_rs1 && (w_rd1 == w_rs1_in)) ||
                     (w_uses_rs2 && (w_rd1 == w_rs2_in)));
`else
  assign w_ld_use = 1'b0;
`endif

  // Flush outranks stall; reset silences the external stall request.
  assign w_stall       = w_ld_use && !bus.flush;
  assign bus.stall_out = w_stall && !rst;

  // Advance the two-stage buffer chain, inserting bubbles on flush/stall.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of its source (r_ir2 gets the old r_ir1).
    if (rst) begin
      r_ir1    <= NOP;
      r_ir2    <= NOP;
      r_pc1    <= 32'd0;
      r_pc2    <= 32'd0;
      r_valid1 <= 1'b0;
      r_valid2 <= 1'b0;
    end else if (bus.en) begin
      r_ir2    <= r_ir1;
      r_pc2    <= r_pc1;
      r_valid2 <= r_valid1;
      if (bus.flush) begin
        r_ir1    <= NOP;
        r_pc1    <= 32'd0;
        r_valid1 <= 1'b0;
      end else if (w_stall) begin
        r_ir1    <= NOP;
        r_pc1    <= bus.pc_in;
        r_valid1 <= 1'b0;
      end else begin
        r_ir1    <= bus.inst_in;
        r_pc1    <= bus.pc_in;
        r_valid1 <= 1'b1;
      end
    end
  end

  assign bus.irbuffer1_out = r_ir1;
  assign bus.irbuffer2_out = r_ir2;
  assign bus.pc1_out       = r_pc1;
  assign bus.pc2_out       = r_pc2;
  assign bus.valid1_out    = r_valid1;
  assign bus.valid2_out    = r_valid2;
endmodule

// File: tb/tb_pipe_ir_buffer.sv
// tb_pipe_ir_buffer: directed bench for pipe_ir_buffer. Expected stall
// behaviour follows whether LOAD_USE_STALL_EN is defined for the build.
module tb_pipe_ir_buffer;
  localparam logic [31:0] NOP      = 32'h0000_0013;
  localparam logic [31:0] ADDI     = 32'h0050_0093; // addi x1,x0,5
  localparam logic [31:0] LW       = 32'h0001_2283; // lw x5,0(x2)
  localparam logic [31:0] ADD_DEP  = 32'h0012_8333; // add x6,x5,x1
  localparam logic [31:0] ADD_ND   = 32'h0013_8333; // add x6,x7,x1
  localparam logic [31:0] LW_X0    = 32'h0001_2003; // lw x0,0(x2)
  localparam logic [31:0] ADD_X0   = 32'h0000_0333; // add x6,x0,x0
  localparam logic [31:0] BEQ      = 32'h0000_0463; // beq x0,x0,8
  localparam logic [31:0] ADDI2    = 32'h0010_0113; // addi x2,x0,1

`ifdef LOAD_USE_STALL_EN
  localparam logic [31:0] STALL_EXP = 32'd1;
`else
  localparam logic [31:0] STALL_EXP = 32'd0;
`endif

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;

  pipe_ir_buffer_if bus ();

  pipe_ir_buffer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_b1(input string tag, input logic [31:0] ir,
                          input logic [31:0] pc, input logic [31:0] v);
    check({tag, " ir1"}, bus.irbuffer1_out, ir);
    check({tag, " pc1"}, bus.pc1_out, pc);
    check({tag, " v1"}, {31'd0, bus.valid1_out}, v);
  endtask

  task automatic check_b2(input string tag, input logic [31:0] ir,
                          input logic [31:0] pc, input logic [31:0] v);
    check({tag, " ir2"}, bus.irbuffer2_out, ir);
    check({tag, " pc2"}, bus.pc2_out, pc);
    check({tag, " v2"}, {31'd0, bus.valid2_out}, v);
  endtask

  task automatic check_stall(input string tag, input logic [31:0] exp);
    check({tag, " stall"}, {31'd0, bus.stall_out}, exp);
  endtask

  initial begin
    n_vec       = 0;
    n_err       = 0;
    rst         = 1'b1;
    bus.en      = 1'b1;
    bus.inst_in = ADDI;
    bus.pc_in   = 32'h40;
    bus.flush   = 1'b0;
    tick();
    tick();

    // Reset state
    check_b1("reset", NOP, 32'd0, 32'd0);
    check_b2("reset", NOP, 32'd0, 32'd0);
    check_stall("reset", 32'd0);

    // Basic latency: addi then lw
    rst         = 1'b0;
    bus.inst_in = ADDI;
    bus.pc_in   = 32'h0;
    tick();
    check_b1("lat1", ADDI, 32'h0, 32'd1);
    check_b2("lat1", NOP, 32'h0, 32'd0);
    bus.inst_in = LW;
    bus.pc_in   = 32'h4;
    tick();
    check_b2("lat2", ADDI, 32'h0, 32'd1);
    check_b1("lat2", LW, 32'h4, 32'd1);

    // Load-use: lw x5 followed by add using x5
    bus.inst_in = ADD_DEP;
    bus.pc_in   = 32'h8;
    #1;
    check_stall("lduse", STALL_EXP);
    tick();
`ifdef LOAD_USE_STALL_EN
    check_b1("lduse bubble", NOP, 32'h8, 32'd0);
    check_b2("lduse bubble", LW, 32'h4, 32'd1);
    check_stall("lduse after", 32'd0);
    tick();
    check_b1("lduse replay", ADD_DEP, 32'h8, 32'd1);
    check_b2("lduse replay", NOP, 32'h8, 32'd0);
`else
    check_b1("lduse direct", ADD_DEP, 32'h8, 32'd1);
    check_b2("lduse direct", LW, 32'h4, 32'd1);
    check_stall("lduse after", 32'd0);
`endif

    // No dependency: lw x5 followed by add x6,x7,x1
    bus.inst_in = LW;
    bus.pc_in   = 32'hC;
    tick();
    check_b1("nodep lw", LW, 32'hC, 32'd1);
    check_b2("nodep lw", ADD_DEP, 32'h8, 32'd1);
    bus.inst_in = ADD_ND;
    bus.pc_in   = 32'h10;
    #1;
    check_stall("nodep", 32'd0);
    tick();
    check_b1("nodep add", ADD_ND, 32'h10, 32'd1);
    check_b2("nodep add", LW, 32'hC, 32'd1);

    // lw x0 followed by add reading x0: never a hazard
    bus.inst_in = LW_X0;
    bus.pc_in   = 32'h14;
    tick();
    bus.inst_in = ADD_X0;
    bus.pc_in   = 32'h18;
    #1;
    check_stall("x0", 32'd0);
    tick();
    check_b1("x0 add", ADD_X0, 32'h18, 32'd1);

    // Flush with beq in buffer1
    bus.inst_in = BEQ;
    bus.pc_in   = 32'h1C;
    tick();
    bus.inst_in = ADDI2;
    bus.pc_in   = 32'h20;
    bus.flush   = 1'b1;
    tick();
    bus.flush   = 1'b0;
    check_b1("flush", NOP, 32'h0, 32'd0);
    check_b2("flush", BEQ, 32'h1C, 32'd1);

    // Flush together with a load-use hazard: flush wins
    bus.inst_in = LW;
    bus.pc_in   = 32'h24;
    tick();
    bus.inst_in = ADD_DEP;
    bus.pc_in   = 32'h28;
    bus.flush   = 1'b1;
    #1;
    check_stall("flush+lduse", 32'd0);
    tick();
    bus.flush   = 1'b0;
    check_b1("flush+lduse", NOP, 32'h0, 32'd0);
    check_b2("flush+lduse", LW, 32'h24, 32'd1);

    // Hold for 3 cycles with a pending hazard
    bus.inst_in = LW;
    bus.pc_in   = 32'h2C;
    tick();
    bus.inst_in = ADD_DEP;
    bus.pc_in   = 32'h30;
    bus.en      = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_b1("hold", LW, 32'h2C, 32'd1);
      check_b2("hold", NOP, 32'h0, 32'd0);
      check_stall("hold", STALL_EXP);
    end
    bus.en = 1'b1;
    tick();
    check_b2("resume", LW, 32'h2C, 32'd1);
`ifdef LOAD_USE_STALL_EN
    check_b1("resume", NOP, 32'h30, 32'd0);
`else
    check_b1("resume", ADD_DEP, 32'h30, 32'd1);
`endif

    // Reset asserted during a stall cycle
    bus.inst_in = LW;
    bus.pc_in   = 32'h34;
    tick();
    bus.inst_in = ADD_DEP;
    bus.pc_in   = 32'h38;
    #1;
    check_stall("rst stall pre", STALL_EXP);
    rst = 1'b1;
    #1;
    check_stall("rst stall hi", 32'd0);
    tick();
    check_b1("rst stall", NOP, 32'd0, 32'd0);
    check_b2("rst stall", NOP, 32'd0, 32'd0);
    check_stall("rst stall", 32'd0);
    rst = 1'b0;
    tick();
    check_b1("post rst", ADD_DEP, 32'h38, 32'd1);
    check_b2("post rst", NOP, 32'd0, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Absolute time bound so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout: observed no completion expected finish");
    $fatal(1, "timeout");
  end
endmodule
